// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 receive model: register map, FSM encoding, frame length.
package max7219_pkg;

   localparam int FRAME_BITS_DEF = 16;
   localparam int SHIFT_W        = 16;

   localparam logic [3:0] ADDR_NOOP      = 4'h0;
   localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
   localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
   localparam logic [3:0] ADDR_DECODE    = 4'h9;
   localparam logic [3:0] ADDR_INTENSITY = 4'hA;
   localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
   localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
   localparam logic [3:0] ADDR_TEST      = 4'hF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } rx_state_t;

   function automatic logic is_digit_addr(input logic [3:0] addr);
      return (addr >= ADDR_DIGIT0) && (addr <= ADDR_DIGIT7);
   endfunction

endpackage

// File: rtl/spi_rx_sync.sv
// Synchroniser for one SPI line: SYNC_STAGES flops, then one extra flop for rise/fall detection.
module spi_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic res,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   // Shift the raw line into the chain and keep the previous synced value.
   always_ff @(posedge clk) begin
      if (res) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], d};
         prev  <= chain[SYNC_STAGES-1];
      end
   end

   assign q    = chain[SYNC_STAGES-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;

endmodule

// File: rtl/max7219_spi_rx.sv
// MAX7219-compatible SPI slave: receives 16-bit frames and holds the register image.
// Optional build macro MAX7219_RX_DOUT_EN adds the spi_dout daisy-chain output.
//
// state | meaning
// IDLE  | waiting for CS low (only after CS has been seen high since reset)
// SHIFT | CS low, shifting one bit per spi_clk rise
// LATCH | one cycle after CS rise: decode and write, or flag a short frame
module max7219_spi_rx
   import max7219_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = FRAME_BITS_DEF
) (
   input  logic        clk,
   input  logic        res,
   input  logic        spi_mosi,
   input  logic        spi_cs,
   input  logic        spi_clk,
`ifdef MAX7219_RX_DOUT_EN
   output logic        spi_dout,
`endif
   output logic [63:0] digits,
   output logic [7:0]  decode_mode,
   output logic [3:0]  intensity,
   output logic [2:0]  scan_limit,
   output logic        shutdown_n,
   output logic        display_test,
   output logic        frame_valid,
   output logic        frame_error,
   output logic [3:0]  last_addr,
   output logic [7:0]  last_data
);

   logic cs_q, cs_rise, cs_fall;
   logic sck_q, sck_rise, sck_fall;
   logic mosi_q, mosi_rise, mosi_fall;

   spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .clk(clk), .res(res), .d(spi_cs), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
   );
   spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
      .clk(clk), .res(res), .d(spi_clk), .q(sck_q), .rise(sck_rise), .fall(sck_fall)
   );
   spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(clk), .res(res), .d(spi_mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
   );

   rx_state_t          state_q, state_d;
   logic               armed_q;
   logic [SHIFT_W-1:0] shift_q;
   logic [4:0]         bit_cnt_q;
   logic               clr_frame, shift_en, latch_en;

   logic               frame_ok;
   logic [3:0]         frame_addr;
   logic [7:0]         frame_data;
   logic [3:0]         addr_m1;
   logic [2:0]         digit_sel;

   // State register.
   always_ff @(posedge clk) begin
      if (res) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and per-cycle datapath controls.
   always_comb begin
      state_d   = state_q;
      clr_frame = 1'b0;
      shift_en  = 1'b0;
      latch_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (armed_q && !cs_q) begin
               state_d   = SHIFT;
               clr_frame = 1'b1;
            end
         end
         SHIFT: begin
            shift_en = sck_rise & ~cs_q;
            if (cs_rise) state_d = LATCH;
         end
         LATCH: begin
            latch_en = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // CS must be seen high after reset before a frame may start, so a frame
   // interrupted by reset is never captured partially.
   always_ff @(posedge clk) begin
      if (res)       armed_q <= 1'b0;
      else if (cs_q) armed_q <= 1'b1;
   end

   // Shift register and saturating bit counter.
   always_ff @(posedge clk) begin
      if (res || clr_frame) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else if (shift_en) begin
         shift_q <= {shift_q[SHIFT_W-2:0], mosi_q};
         if (bit_cnt_q != 5'd31) bit_cnt_q <= bit_cnt_q + 5'd1;
      end
   end

   assign frame_ok   = latch_en && (int'(bit_cnt_q) >= FRAME_BITS);
   assign frame_addr = shift_q[11:8];
   assign frame_data = shift_q[7:0];
   assign addr_m1    = frame_addr - 4'd1;
   assign digit_sel  = addr_m1[2:0];

   // Register image writes and frame strobes, all taking effect at the end of LATCH.
   always_ff @(posedge clk) begin
      if (res) begin
         digits       <= '0;
         decode_mode  <= '0;
         intensity    <= '0;
         scan_limit   <= '0;
         shutdown_n   <= 1'b0;
         display_test <= 1'b0;
         frame_valid  <= 1'b0;
         frame_error  <= 1'b0;
         last_addr    <= '0;
         last_data    <= '0;
      end else begin
         frame_valid <= frame_ok;
         frame_error <= latch_en && !frame_ok;
         if (frame_ok) begin
            last_addr <= frame_addr;
            last_data <= frame_data;
            if (is_digit_addr(frame_addr)) digits[{digit_sel, 3'b000} +: 8] <= frame_data;
            case (frame_addr)
               ADDR_DECODE:    decode_mode  <= frame_data;
               ADDR_INTENSITY: intensity    <= frame_data[3:0];
               ADDR_SCANLIM:   scan_limit   <= frame_data[2:0];
               ADDR_SHUTDOWN:  shutdown_n   <= frame_data[0];
               ADDR_TEST:      display_test <= frame_data[0];
               default: ;
            endcase
         end
      end
   end

`ifdef MAX7219_RX_DOUT_EN
   // DOUT presents the bit leaving the top of the shift register on each spi_clk fall.
   always_ff @(posedge clk) begin
      if (res)                                      spi_dout <= 1'b0;
      else if (state_q == SHIFT && sck_fall && !cs_q) spi_dout <= shift_q[SHIFT_W-1];
   end
`endif

   logic unused_sigs;
   assign unused_sigs = ^{cs_fall, sck_q, sck_fall, mosi_rise, mosi_fall, shift_q[15:12], addr_m1[3]};

endmodule

// File: tb/tb_max7219_spi_rx.sv
// Directed, table-driven bench for max7219_spi_rx (define MAX7219_RX_DOUT_EN to cover spi_dout).
module tb_max7219_spi_rx;

   logic        clk = 1'b0;
   logic        res, spi_mosi, spi_cs, spi_clk;
   logic [63:0] digits;
   logic [7:0]  decode_mode, last_data;
   logic [3:0]  intensity, last_addr;
   logic [2:0]  scan_limit;
   logic        shutdown_n, display_test, frame_valid, frame_error;
`ifdef MAX7219_RX_DOUT_EN
   logic        spi_dout;
`endif

   max7219_spi_rx dut (
      .clk(clk), .res(res), .spi_mosi(spi_mosi), .spi_cs(spi_cs), .spi_clk(spi_clk),
`ifdef MAX7219_RX_DOUT_EN
      .spi_dout(spi_dout),
`endif
      .digits(digits), .decode_mode(decode_mode), .intensity(intensity), .scan_limit(scan_limit),
      .shutdown_n(shutdown_n), .display_test(display_test), .frame_valid(frame_valid),
      .frame_error(frame_error), .last_addr(last_addr), .last_data(last_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int valid_cnt = 0;
   int error_cnt = 0;

   always @(negedge clk) begin
      if (frame_valid) valid_cnt++;
      if (frame_error) error_cnt++;
   end

   typedef struct {
      logic [31:0] word;
      int          nbits;
      logic [63:0] digits;
      logic [7:0]  decode;
      logic [3:0]  inten;
      logic [2:0]  scan;
      logic        sd;
      logic        test;
      logic [3:0]  addr;
      logic [7:0]  data;
      int          nvalid;
      int          nerr;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [31:0] word, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         spi_mosi = word[i];
         wait_neg(4);
         spi_clk = 1'b1;
         wait_neg(4);
         spi_clk = 1'b0;
      end
      wait_neg(4);
   endtask

   task automatic cs_low();
      spi_cs = 1'b0;
      wait_neg(4);
   endtask

   task automatic cs_high();
      spi_cs = 1'b1;
      wait_neg(10);
   endtask

   task automatic send_frame(input logic [31:0] word, input int nbits);
      cs_low();
      send_bits(word, nbits);
      cs_high();
   endtask

   task automatic check_regs(input string tag, input vec_t v);
      check({tag, " digits"},       digits,       v.digits);
      check({tag, " decode_mode"},  decode_mode,  64'(v.decode));
      check({tag, " intensity"},    intensity,    64'(v.inten));
      check({tag, " scan_limit"},   scan_limit,   64'(v.scan));
      check({tag, " shutdown_n"},   shutdown_n,   64'(v.sd));
      check({tag, " display_test"}, display_test, 64'(v.test));
      check({tag, " last_addr"},    last_addr,    64'(v.addr));
      check({tag, " last_data"},    last_data,    64'(v.data));
   endtask

   initial begin
      int v0, e0;
      vec_t zero_v;

      //          word          nbits digits                 dec    int   scan  sd    test  addr  data   nv nerr
      vecs[0]  = '{32'h0000_0A07, 16, 64'h0,                 8'h00, 4'h7, 3'd0, 1'b0, 1'b0, 4'hA, 8'h07, 1, 0};
      vecs[1]  = '{32'h0000_0C01, 16, 64'h0,                 8'h00, 4'h7, 3'd0, 1'b1, 1'b0, 4'hC, 8'h01, 1, 0};
      vecs[2]  = '{32'h0000_0105, 16, 64'h05,                8'h00, 4'h7, 3'd0, 1'b1, 1'b0, 4'h1, 8'h05, 1, 0};
      vecs[3]  = '{32'h0000_0809, 16, 64'h0900_0000_0000_0005, 8'h00, 4'h7, 3'd0, 1'b1, 1'b0, 4'h8, 8'h09, 1, 0};
      vecs[4]  = '{32'h0000_0ABC, 12, 64'h0900_0000_0000_0005, 8'h00, 4'h7, 3'd0, 1'b1, 1'b0, 4'h8, 8'h09, 0, 1};
      vecs[5]  = '{32'h00FF_0B05, 24, 64'h0900_0000_0000_0005, 8'h00, 4'h7, 3'd5, 1'b1, 1'b0, 4'hB, 8'h05, 1, 0};
      vecs[6]  = '{32'h0000_09FF, 16, 64'h0900_0000_0000_0005, 8'hFF, 4'h7, 3'd5, 1'b1, 1'b0, 4'h9, 8'hFF, 1, 0};
      vecs[7]  = '{32'h0000_0AF3, 16, 64'h0900_0000_0000_0005, 8'hFF, 4'h3, 3'd5, 1'b1, 1'b0, 4'hA, 8'hF3, 1, 0};
      vecs[8]  = '{32'h0000_0D55, 16, 64'h0900_0000_0000_0005, 8'hFF, 4'h3, 3'd5, 1'b1, 1'b0, 4'hD, 8'h55, 1, 0};
      vecs[9]  = '{32'h0000_0000, 16, 64'h0900_0000_0000_0005, 8'hFF, 4'h3, 3'd5, 1'b1, 1'b0, 4'h0, 8'h00, 1, 0};
      vecs[10] = '{32'h0000_FC02, 16, 64'h0900_0000_0000_0005, 8'hFF, 4'h3, 3'd5, 1'b0, 1'b0, 4'hC, 8'h02, 1, 0};
      vecs[11] = '{32'h0000_0BFE, 16, 64'h0900_0000_0000_0005, 8'hFF, 4'h3, 3'd6, 1'b0, 1'b0, 4'hB, 8'hFE, 1, 0};
      vecs[12] = '{32'h0000_0C03, 16, 64'h0900_0000_0000_0005, 8'hFF, 4'h3, 3'd6, 1'b1, 1'b0, 4'hC, 8'h03, 1, 0};
      vecs[13] = '{32'h0000_0420, 16, 64'h0900_0000_2000_0005, 8'hFF, 4'h3, 3'd6, 1'b1, 1'b0, 4'h4, 8'h20, 1, 0};
      vecs[14] = '{32'h0001_0A05, 17, 64'h0900_0000_2000_0005, 8'hFF, 4'h5, 3'd6, 1'b1, 1'b0, 4'hA, 8'h05, 1, 0};
      vecs[15] = '{32'h0000_0A01, 15, 64'h0900_0000_2000_0005, 8'hFF, 4'h5, 3'd6, 1'b1, 1'b0, 4'hA, 8'h05, 0, 1};
      zero_v   = '{32'h0, 0, 64'h0, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0, 4'h0, 8'h00, 0, 0};

      res = 1'b1; spi_cs = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
      wait_neg(3);
      res = 1'b0;
      wait_neg(6);
      check_regs("reset", zero_v);
      check("reset frame_valid", frame_valid, 64'd0);
      check("reset frame_error", frame_error, 64'd0);

      for (int i = 0; i < 16; i++) begin
         v0 = valid_cnt; e0 = error_cnt;
         send_frame(vecs[i].word, vecs[i].nbits);
         check_regs($sformatf("vec%0d", i), vecs[i]);
         check($sformatf("vec%0d valid pulses", i), 64'(valid_cnt - v0), 64'(vecs[i].nvalid));
         check($sformatf("vec%0d error pulses", i), 64'(error_cnt - e0), 64'(vecs[i].nerr));
      end

      // Reset after 9 bits of a frame; the remainder must not be captured.
      cs_low();
      send_bits(32'h0F01 >> 7, 9);
      res = 1'b1;
      wait_neg(1);
      res = 1'b0;
      v0 = valid_cnt; e0 = error_cnt;
      send_bits(32'h0F01, 7);
      cs_high();
      check_regs("midreset", zero_v);
      check("midreset valid pulses", 64'(valid_cnt - v0), 64'd0);
      check("midreset error pulses", 64'(error_cnt - e0), 64'd0);
      send_frame(32'h0F01, 16);
      check("post-reset display_test", display_test, 64'd1);
      check("post-reset valid pulses", 64'(valid_cnt - v0), 64'd1);

      // Latency from raw CS rise to outputs: four clk edges.
      cs_low();
      send_bits(32'h0A09, 16);
      spi_cs = 1'b1;
      wait_neg(3);
      check("latency intensity early", intensity, 64'h0);
      check("latency valid early", frame_valid, 64'd0);
      wait_neg(1);
      check("latency intensity", intensity, 64'h9);
      check("latency valid", frame_valid, 64'd1);
      wait_neg(1);
      check("latency valid width", frame_valid, 64'd0);
      wait_neg(8);

`ifdef MAX7219_RX_DOUT_EN
      begin
         logic [31:0] w;
         logic [15:0] first;
         w = 32'h0A03_0000;
         first = 16'h0A03;
         cs_low();
         for (int k = 1; k <= 32; k++) begin
            spi_mosi = w[32-k];
            wait_neg(4);
            if (k >= 17) check($sformatf("dout clock %0d", k), spi_dout, 64'(first[32-k]));
            spi_clk = 1'b1;
            wait_neg(4);
            spi_clk = 1'b0;
         end
         wait_neg(4);
         cs_high();
         check("dout frame last_addr", last_addr, 64'h0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
